// File: rtl/rs_alu_station_if.sv
// Issue, register-status, CDB and ALU-dispatch bundle of the ALU reservation station.
// The station connects through the slave view; the environment uses the master view.
interface rs_alu_station_if #(
  parameter int FU_NUM        = 2,
  parameter int REG_VAL_WIDTH = 64,
  parameter int PHYS_REG_W    = 5,
  parameter int ALU_OP_W      = 4
);
  logic                            new_valid_inst;
  logic [ALU_OP_W-1:0]             ctrl_alu_op;
  logic                            ctrl_use_imm;
  logic                            ctrl_reg_wb;
  logic [PHYS_REG_W-1:0]           src_reg1_addr;
  logic [PHYS_REG_W-1:0]           src_reg2_addr;
  logic [REG_VAL_WIDTH-1:0]        src_reg1_val;
  logic [REG_VAL_WIDTH-1:0]        src_reg2_val;
  logic [PHYS_REG_W-1:0]           dst_reg_addr;
  logic [REG_VAL_WIDTH-1:0]        immediate;
  logic                            rs_full;
  logic [PHYS_REG_W-1:0]           stat_src1_addr;
  logic [PHYS_REG_W-1:0]           stat_src2_addr;
  logic                            stat_src1_ready;
  logic                            stat_src2_ready;
  logic                            stat_set_busy;
  logic [PHYS_REG_W-1:0]           stat_dst_addr;
  logic [FU_NUM-1:0]               cdb_valid;
  logic [FU_NUM*PHYS_REG_W-1:0]    cdb_tag;
  logic [FU_NUM*REG_VAL_WIDTH-1:0] cdb_val;
  logic [FU_NUM-1:0]               fu_ready;
  logic [FU_NUM-1:0]               fu_valid;
  logic [FU_NUM*REG_VAL_WIDTH-1:0] fu_op1;
  logic [FU_NUM*REG_VAL_WIDTH-1:0] fu_op2;
  logic [FU_NUM*PHYS_REG_W-1:0]    fu_dst;
  logic [FU_NUM*ALU_OP_W-1:0]      fu_alu_op;
  logic [FU_NUM-1:0]               fu_reg_wb;

  // Handshake: an issue is taken on a clk edge where new_valid_inst=1 and rs_full=0
  // (otherwise dropped). ALU i is picked on an edge where fu_ready[i]=1 and an entry is
  // eligible; fu_valid[i] then pulses for exactly the following cycle with the payload,
  // and the payload holds after the pulse ends.
  modport master (
    output new_valid_inst, ctrl_alu_op, ctrl_use_imm, ctrl_reg_wb,
    output src_reg1_addr, src_reg2_addr, src_reg1_val, src_reg2_val,
    output dst_reg_addr, immediate, stat_src1_ready, stat_src2_ready,
    output cdb_valid, cdb_tag, cdb_val, fu_ready,
    input  rs_full, stat_src1_addr, stat_src2_addr, stat_set_busy, stat_dst_addr,
    input  fu_valid, fu_op1, fu_op2, fu_dst, fu_alu_op, fu_reg_wb
  );

  modport slave (
    input  new_valid_inst, ctrl_alu_op, ctrl_use_imm, ctrl_reg_wb,
    input  src_reg1_addr, src_reg2_addr, src_reg1_val, src_reg2_val,
    input  dst_reg_addr, immediate, stat_src1_ready, stat_src2_ready,
    input  cdb_valid, cdb_tag, cdb_val, fu_ready,
    output rs_full, stat_src1_addr, stat_src2_addr, stat_set_busy, stat_dst_addr,
    output fu_valid, fu_op1, fu_op2, fu_dst, fu_alu_op, fu_reg_wb
  );
endinterface

// File: rtl/rs_alu_station.sv
// ALU reservation station: allocates renamed ops, wakes operands from the CDB and
// dispatches ready entries to up to FU_NUM ALUs, lowest entry index first.
module rs_alu_station #(
  parameter int RS_ENTRIES_NUM = 8,
  parameter int FU_NUM         = 2,
  parameter int REG_VAL_WIDTH  = 64,
  parameter int PHYS_REG_W     = 5,
  parameter int ALU_OP_W       = 4
) (
  input logic            clk,
  input logic            reset,
  rs_alu_station_if.slave bus
);
  localparam int IDX_W = (RS_ENTRIES_NUM > 1) ? $clog2(RS_ENTRIES_NUM) : 1;

  logic [RS_ENTRIES_NUM-1:0] ent_valid, ent_rdy1, ent_rdy2, ent_wb;
  logic [REG_VAL_WIDTH-1:0]  ent_op1 [RS_ENTRIES_NUM];
  logic [REG_VAL_WIDTH-1:0]  ent_op2 [RS_ENTRIES_NUM];
  logic [PHYS_REG_W-1:0]     ent_tag1 [RS_ENTRIES_NUM];
  logic [PHYS_REG_W-1:0]     ent_tag2 [RS_ENTRIES_NUM];
  logic [PHYS_REG_W-1:0]     ent_dst [RS_ENTRIES_NUM];
  logic [ALU_OP_W-1:0]       ent_alu_op [RS_ENTRIES_NUM];

  logic [PHYS_REG_W-1:0]     lane_tag [FU_NUM];
  logic [REG_VAL_WIDTH-1:0]  lane_val [FU_NUM];

  always_comb begin
    for (int l = 0; l < FU_NUM; l++) begin
      lane_tag[l] = bus.cdb_tag[l*PHYS_REG_W +: PHYS_REG_W];
      lane_val[l] = bus.cdb_val[l*REG_VAL_WIDTH +: REG_VAL_WIDTH];
    end
  end

  // Allocation
  logic             full, alloc_en;
  logic [IDX_W-1:0] free_idx;

  assign full     = &ent_valid;
  assign alloc_en = bus.new_valid_inst & ~full;

  always_comb begin
    free_idx = '0;
    for (int e = RS_ENTRIES_NUM - 1; e >= 0; e--)
      if (!ent_valid[e]) free_idx = IDX_W'(e);
  end

  // Same-cycle CDB capture for the incoming operands; descending scan lets lane 0 win.
  logic                     hit1, hit2, new_rdy1, new_rdy2;
  logic [REG_VAL_WIDTH-1:0] cdb1, cdb2, new_op1, new_op2;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    cdb1 = '0;
    cdb2 = '0;
    for (int l = FU_NUM - 1; l >= 0; l--) begin
      if (bus.cdb_valid[l] && lane_tag[l] == bus.src_reg1_addr) begin
        hit1 = 1'b1;
        cdb1 = lane_val[l];
      end
      if (bus.cdb_valid[l] && lane_tag[l] == bus.src_reg2_addr) begin
        hit2 = 1'b1;
        cdb2 = lane_val[l];
      end
    end
    new_rdy1 = bus.stat_src1_ready | hit1 | (bus.src_reg1_addr == '0);
    new_op1  = hit1 ? cdb1 : bus.src_reg1_val;
    new_rdy2 = bus.ctrl_use_imm | bus.stat_src2_ready | hit2 | (bus.src_reg2_addr == '0);
    new_op2  = bus.ctrl_use_imm ? bus.immediate : (hit2 ? cdb2 : bus.src_reg2_val);
  end

  // Wakeup of resident entries
  logic [RS_ENTRIES_NUM-1:0] wake1, wake2;
  logic [REG_VAL_WIDTH-1:0]  wake1_val [RS_ENTRIES_NUM];
  logic [REG_VAL_WIDTH-1:0]  wake2_val [RS_ENTRIES_NUM];

  always_comb begin
    for (int e = 0; e < RS_ENTRIES_NUM; e++) begin
      wake1[e]     = 1'b0;
      wake2[e]     = 1'b0;
      wake1_val[e] = '0;
      wake2_val[e] = '0;
      for (int l = FU_NUM - 1; l >= 0; l--) begin
        if (ent_valid[e] && !ent_rdy1[e] && bus.cdb_valid[l] && lane_tag[l] == ent_tag1[e]) begin
          wake1[e]     = 1'b1;
          wake1_val[e] = lane_val[l];
        end
        if (ent_valid[e] && !ent_rdy2[e] && bus.cdb_valid[l] && lane_tag[l] == ent_tag2[e]) begin
          wake2[e]     = 1'b1;
          wake2_val[e] = lane_val[l];
        end
      end
    end
  end

  // Dispatch select: each ready ALU in ascending order takes the lowest unpicked eligible entry.
  logic [RS_ENTRIES_NUM-1:0] eligible, picked;
  logic [FU_NUM-1:0]         pick_valid;
  logic [IDX_W-1:0]          pick_idx [FU_NUM];

  assign eligible = ent_valid & ent_rdy1 & ent_rdy2;

  always_comb begin
    picked = '0;
    for (int f = 0; f < FU_NUM; f++) begin
      pick_valid[f] = 1'b0;
      pick_idx[f]   = '0;
      if (bus.fu_ready[f]) begin
        for (int e = RS_ENTRIES_NUM - 1; e >= 0; e--) begin
          if (eligible[e] && !picked[e]) begin
            pick_valid[f] = 1'b1;
            pick_idx[f]   = IDX_W'(e);
          end
        end
      end
      if (pick_valid[f]) picked[pick_idx[f]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      ent_rdy1  <= '0;
      ent_rdy2  <= '0;
      ent_wb    <= '0;
      for (int e = 0; e < RS_ENTRIES_NUM; e++) begin
        ent_op1[e]    <= '0;
        ent_op2[e]    <= '0;
        ent_tag1[e]   <= '0;
        ent_tag2[e]   <= '0;
        ent_dst[e]    <= '0;
        ent_alu_op[e] <= '0;
      end
    end else begin
      for (int e = 0; e < RS_ENTRIES_NUM; e++) begin
        if (wake1[e]) begin
          ent_rdy1[e] <= 1'b1;
          ent_op1[e]  <= wake1_val[e];
        end
        if (wake2[e]) begin
          ent_rdy2[e] <= 1'b1;
          ent_op2[e]  <= wake2_val[e];
        end
        if (picked[e]) ent_valid[e] <= 1'b0;
      end
      // The free slot is never a picked or waking entry, so these writes cannot collide.
      if (alloc_en) begin
        ent_valid[free_idx]  <= 1'b1;
        ent_rdy1[free_idx]   <= new_rdy1;
        ent_rdy2[free_idx]   <= new_rdy2;
        ent_op1[free_idx]    <= new_op1;
        ent_op2[free_idx]    <= new_op2;
        ent_tag1[free_idx]   <= bus.src_reg1_addr;
        ent_tag2[free_idx]   <= bus.src_reg2_addr;
        ent_dst[free_idx]    <= bus.dst_reg_addr;
        ent_alu_op[free_idx] <= bus.ctrl_alu_op;
        ent_wb[free_idx]     <= bus.ctrl_reg_wb;
      end
    end
  end

  // ALU payload registers
  logic [FU_NUM-1:0]        fu_valid_q, fu_wb_q;
  logic [REG_VAL_WIDTH-1:0] fu_op1_q [FU_NUM];
  logic [REG_VAL_WIDTH-1:0] fu_op2_q [FU_NUM];
  logic [PHYS_REG_W-1:0]    fu_dst_q [FU_NUM];
  logic [ALU_OP_W-1:0]      fu_aop_q [FU_NUM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fu_valid_q <= '0;
      fu_wb_q    <= '0;
      for (int f = 0; f < FU_NUM; f++) begin
        fu_op1_q[f] <= '0;
        fu_op2_q[f] <= '0;
        fu_dst_q[f] <= '0;
        fu_aop_q[f] <= '0;
      end
    end else begin
      fu_valid_q <= pick_valid;
      for (int f = 0; f < FU_NUM; f++) begin
        if (pick_valid[f]) begin
          fu_op1_q[f] <= ent_op1[pick_idx[f]];
          fu_op2_q[f] <= ent_op2[pick_idx[f]];
          fu_dst_q[f] <= ent_dst[pick_idx[f]];
          fu_aop_q[f] <= ent_alu_op[pick_idx[f]];
          fu_wb_q[f]  <= ent_wb[pick_idx[f]];
        end
      end
    end
  end

  logic [FU_NUM*REG_VAL_WIDTH-1:0] op1_flat, op2_flat;
  logic [FU_NUM*PHYS_REG_W-1:0]    dst_flat;
  logic [FU_NUM*ALU_OP_W-1:0]      aop_flat;

  always_comb begin
    op1_flat = '0;
    op2_flat = '0;
    dst_flat = '0;
    aop_flat = '0;
    for (int f = 0; f < FU_NUM; f++) begin
      op1_flat[f*REG_VAL_WIDTH +: REG_VAL_WIDTH] = fu_op1_q[f];
      op2_flat[f*REG_VAL_WIDTH +: REG_VAL_WIDTH] = fu_op2_q[f];
      dst_flat[f*PHYS_REG_W +: PHYS_REG_W]       = fu_dst_q[f];
      aop_flat[f*ALU_OP_W +: ALU_OP_W]           = fu_aop_q[f];
    end
  end

  assign bus.fu_valid       = fu_valid_q;
  assign bus.fu_reg_wb      = fu_wb_q;
  assign bus.fu_op1         = op1_flat;
  assign bus.fu_op2         = op2_flat;
  assign bus.fu_dst         = dst_flat;
  assign bus.fu_alu_op      = aop_flat;
  assign bus.rs_full        = full;
  assign bus.stat_src1_addr = bus.src_reg1_addr;
  assign bus.stat_src2_addr = bus.src_reg2_addr;
  assign bus.stat_dst_addr  = bus.dst_reg_addr;
  assign bus.stat_set_busy  = reset & alloc_en & bus.ctrl_reg_wb & (bus.dst_reg_addr != '0);
endmodule

// File: tb/tb_rs_alu_station.sv
// Directed bench for rs_alu_station: an entry-list model checked every cycle, a queue of
// hand-computed dispatch records, and literal pins at the key cycles.
module tb_rs_alu_station;
  localparam int N  = 8;
  localparam int F  = 2;
  localparam int W  = 64;
  localparam int PW = 5;
  localparam int OW = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rs_alu_station_if #(.FU_NUM(F), .REG_VAL_WIDTH(W), .PHYS_REG_W(PW), .ALU_OP_W(OW)) bus ();

  rs_alu_station #(
    .RS_ENTRIES_NUM(N), .FU_NUM(F), .REG_VAL_WIDTH(W), .PHYS_REG_W(PW), .ALU_OP_W(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected dispatches as {dst, op1, op2}, in lane order within a cycle
  logic [PW+2*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // behavioural model: a list of waiting ops plus the last payload sent to each ALU
  typedef struct {
    bit            v;
    bit            r1, r2;
    logic [W-1:0]  o1, o2;
    logic [PW-1:0] t1, t2, dst;
    logic [OW-1:0] op;
    bit            wb;
  } op_t;

  op_t           m [N];
  logic [F-1:0]  e_valid, e_wb;
  logic [W-1:0]  e_op1 [F];
  logic [W-1:0]  e_op2 [F];
  logic [PW-1:0] e_dst [F];
  logic [OW-1:0] e_aop [F];

  function automatic bit cdb_hit(input logic [PW-1:0] tag, output logic [W-1:0] val);
    for (int l = 0; l < F; l++)
      if (bus.cdb_valid[l] && bus.cdb_tag[l*PW +: PW] == tag) begin
        val = bus.cdb_val[l*W +: W];
        return 1'b1;
      end
    val = '0;
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int e = 0; e < N; e++) if (!m[e].v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int e = 0; e < N; e++) m[e] = '{default: '0};
    e_valid = '0;
    e_wb    = '0;
    for (int f = 0; f < F; f++) begin
      e_op1[f] = '0; e_op2[f] = '0; e_dst[f] = '0; e_aop[f] = '0;
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now on the bus.
  task automatic model_step();
    op_t          nxt [N];
    bit           used [N];
    bit           full;
    int           slot;
    logic [W-1:0] v;
    full = model_full();
    slot = -1;
    for (int e = N - 1; e >= 0; e--) begin
      used[e] = 1'b0;
      if (!m[e].v) slot = e;
    end
    nxt = m;
    e_valid = '0;
    for (int f = 0; f < F; f++) begin
      if (!bus.fu_ready[f]) continue;
      for (int e = 0; e < N; e++) begin
        if (m[e].v && m[e].r1 && m[e].r2 && !used[e]) begin
          used[e] = 1'b1; e_valid[f] = 1'b1; nxt[e].v = 1'b0;
          e_op1[f] = m[e].o1; e_op2[f] = m[e].o2; e_dst[f] = m[e].dst;
          e_aop[f] = m[e].op; e_wb[f] = m[e].wb;
          break;
        end
      end
    end
    for (int e = 0; e < N; e++) begin
      if (!m[e].v) continue;
      if (!m[e].r1 && cdb_hit(m[e].t1, v)) begin nxt[e].r1 = 1'b1; nxt[e].o1 = v; end
      if (!m[e].r2 && cdb_hit(m[e].t2, v)) begin nxt[e].r2 = 1'b1; nxt[e].o2 = v; end
    end
    if (bus.new_valid_inst && !full) begin
      nxt[slot].v   = 1'b1;
      nxt[slot].t1  = bus.src_reg1_addr;
      nxt[slot].t2  = bus.src_reg2_addr;
      nxt[slot].dst = bus.dst_reg_addr;
      nxt[slot].op  = bus.ctrl_alu_op;
      nxt[slot].wb  = bus.ctrl_reg_wb;
      if (cdb_hit(bus.src_reg1_addr, v)) begin nxt[slot].r1 = 1'b1; nxt[slot].o1 = v; end
      else begin
        nxt[slot].r1 = bus.stat_src1_ready || bus.src_reg1_addr == 0;
        nxt[slot].o1 = bus.src_reg1_val;
      end
      if (bus.ctrl_use_imm) begin nxt[slot].r2 = 1'b1; nxt[slot].o2 = bus.immediate; end
      else if (cdb_hit(bus.src_reg2_addr, v)) begin nxt[slot].r2 = 1'b1; nxt[slot].o2 = v; end
      else begin
        nxt[slot].r2 = bus.stat_src2_ready || bus.src_reg2_addr == 0;
        nxt[slot].o2 = bus.src_reg2_val;
      end
    end
    m = nxt;
  endtask

  // compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      model_clear();
      chk("reset_fu_valid", bus.fu_valid, 0);
      chk("reset_fu_payload", {bus.fu_op1, bus.fu_dst, bus.fu_reg_wb}, 0);
      chk("reset_rs_full", bus.rs_full, 0);
      chk("reset_set_busy", bus.stat_set_busy, 0);
    end else begin
      chk("rs_full", bus.rs_full, model_full());
      chk("stat_set_busy", bus.stat_set_busy,
          bus.new_valid_inst && !model_full() && bus.ctrl_reg_wb && bus.dst_reg_addr != 0);
      chk("stat_addrs", {bus.stat_src1_addr, bus.stat_src2_addr, bus.stat_dst_addr},
          {bus.src_reg1_addr, bus.src_reg2_addr, bus.dst_reg_addr});
      chk("fu_valid", bus.fu_valid, e_valid);
      for (int f = 0; f < F; f++) begin
        chk($sformatf("fu_payload%0d", f),
            {bus.fu_op1[f*W +: W], bus.fu_op2[f*W +: W], bus.fu_dst[f*PW +: PW],
             bus.fu_alu_op[f*OW +: OW], bus.fu_reg_wb[f]},
            {e_op1[f], e_op2[f], e_dst[f], e_aop[f], e_wb[f]});
        if (bus.fu_valid[f]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dispatch_extra lane=%0d dst=%0d expected no dispatch", f,
                     bus.fu_dst[f*PW +: PW]);
          end else begin
            chk("dispatch_rec",
                {bus.fu_dst[f*PW +: PW], bus.fu_op1[f*W +: W], bus.fu_op2[f*W +: W]},
                exp_q.pop_front());
          end
        end
      end
      model_step();
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.new_valid_inst = 1'b0;
    bus.cdb_valid      = '0;
  endtask

  task automatic issue(input logic [PW-1:0] s1, input bit r1, input logic [W-1:0] v1,
                       input logic [PW-1:0] s2, input bit r2, input logic [W-1:0] v2,
                       input bit use_imm, input logic [W-1:0] imm,
                       input logic [PW-1:0] dst, input logic [OW-1:0] op, input bit wb);
    bus.new_valid_inst  = 1'b1;
    bus.src_reg1_addr   = s1;
    bus.stat_src1_ready = r1;
    bus.src_reg1_val    = v1;
    bus.src_reg2_addr   = s2;
    bus.stat_src2_ready = r2;
    bus.src_reg2_val    = v2;
    bus.ctrl_use_imm    = use_imm;
    bus.immediate       = imm;
    bus.dst_reg_addr    = dst;
    bus.ctrl_alu_op     = op;
    bus.ctrl_reg_wb     = wb;
  endtask

  task automatic cdb(input int lane, input logic [PW-1:0] tag, input logic [W-1:0] val);
    bus.cdb_valid[lane]          = 1'b1;
    bus.cdb_tag[lane*PW +: PW]   = tag;
    bus.cdb_val[lane*W +: W]     = val;
  endtask

  initial begin
    reset    = 1'b0;
    bus.cdb_tag = '0;
    bus.cdb_val = '0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    bus.fu_ready = 2'b11;
    #3;
    chk("pin_reset_outputs", {bus.fu_valid, bus.rs_full, bus.stat_set_busy, bus.fu_dst}, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // independent op: R2(15) + R1(9) -> R3
    issue(2, 1, 15, 1, 1, 9, 0, 0, 3, 0, 1);
    exp_q.push_back({5'd3, 64'd15, 64'd9});
    #1;
    chk("pin_set_busy_r3", {bus.stat_set_busy, bus.stat_dst_addr}, {1'b1, 5'd3});
    tick(); idle();
    chk("pin_no_dispatch_at_alloc", bus.fu_valid, 2'b00);
    tick();
    chk("pin_indep_dispatch", {bus.fu_valid, bus.fu_op1[63:0], bus.fu_op2[63:0], bus.fu_dst[4:0]},
        {2'b01, 64'd15, 64'd9, 5'd3});
    tick();

    // dependent op on R3 with immediate 33 -> R4; woken by lane 0 tag 3 value 24
    issue(3, 0, 99, 0, 0, 0, 1, 33, 4, 1, 1);
    exp_q.push_back({5'd4, 64'd24, 64'd33});
    tick(); idle(); tick(); tick();
    chk("pin_dep_waits", bus.fu_valid, 2'b00);
    cdb(0, 3, 24);
    tick(); idle();
    chk("pin_woken_not_yet", bus.fu_valid, 2'b00);
    tick();
    chk("pin_dep_dispatch", {bus.fu_valid, bus.fu_op1[63:0], bus.fu_op2[63:0], bus.fu_dst[4:0]},
        {2'b01, 64'd24, 64'd33, 5'd4});
    tick();

    // CDB tag 3 on both lanes during allocation: lane 0 value wins; src2 is R0 (always ready)
    issue(3, 0, 1, 0, 0, 5, 0, 0, 5, 2, 1);
    cdb(0, 3, 77);
    cdb(1, 3, 88);
    exp_q.push_back({5'd5, 64'd77, 64'd5});
    tick(); idle(); tick();
    chk("pin_alloc_capture", {bus.fu_valid, bus.fu_op1[63:0], bus.fu_op2[63:0]},
        {2'b01, 64'd77, 64'd5});
    tick();

    // fill all eight entries waiting on R7
    for (int i = 0; i < N; i++) begin
      issue(7, 0, 0, 0, 0, 0, 1, 64'(100 + i), 5'(8 + i), 4'(i), 1);
      tick();
    end
    idle();
    chk("pin_full", bus.rs_full, 1'b1);
    issue(1, 1, 1, 0, 0, 0, 1, 999, 20, 0, 1);
    #1;
    chk("pin_full_no_busy", bus.stat_set_busy, 1'b0);
    tick(); idle();
    cdb(1, 7, 500);
    for (int i = 0; i < N; i++) exp_q.push_back({5'(8 + i), 64'd500, 64'(100 + i)});
    tick(); idle();
    chk("pin_full_after_wake", {bus.rs_full, bus.fu_valid}, {1'b1, 2'b00});
    tick();
    chk("pin_dual_dispatch", {bus.fu_valid, bus.rs_full}, {2'b11, 1'b0});
    tick(); tick(); tick();
    chk("pin_last_pair", {bus.fu_dst[9:5], bus.fu_dst[4:0]}, {5'd15, 5'd14});
    tick();
    chk("pin_drained", bus.fu_valid, 2'b00);

    // only ALU1 ready
    bus.fu_ready = 2'b10;
    issue(1, 1, 40, 2, 1, 2, 0, 0, 10, 3, 1);
    exp_q.push_back({5'd10, 64'd40, 64'd2});
    tick();
    issue(1, 1, 50, 2, 1, 3, 0, 0, 11, 3, 0);
    exp_q.push_back({5'd11, 64'd50, 64'd3});
    tick(); idle();
    chk("pin_alu1_first", {bus.fu_valid, bus.fu_dst[9:5]}, {2'b10, 5'd10});
    chk("pin_alu0_payload_hold", bus.fu_dst[4:0], 5'd14);
    tick();
    chk("pin_alu1_second", {bus.fu_valid, bus.fu_dst[9:5], bus.fu_reg_wb[1]}, {2'b10, 5'd11, 1'b0});
    tick();
    bus.fu_ready = 2'b11;

    // reset with three waiting entries
    issue(9, 0, 0, 0, 0, 0, 1, 1, 21, 0, 1); tick();
    issue(9, 0, 0, 0, 0, 0, 1, 2, 22, 0, 1); tick();
    issue(9, 0, 0, 0, 0, 0, 1, 3, 23, 0, 1); tick();
    idle();
    reset = 1'b0;
    #1;
    chk("pin_async_reset", {bus.fu_valid, bus.rs_full, bus.fu_op1, bus.fu_dst}, 0);
    tick(); tick();
    reset = 1'b1;
    cdb(0, 9, 7);
    tick(); idle(); tick(); tick();
    chk("pin_no_ghost_dispatch", {bus.fu_valid, bus.rs_full}, 0);
    issue(1, 1, 1, 2, 1, 2, 0, 0, 12, 0, 1);
    exp_q.push_back({5'd12, 64'd1, 64'd2});
    tick(); idle(); tick();
    chk("pin_post_reset_dispatch", {bus.fu_valid, bus.fu_dst[4:0]}, {2'b01, 5'd12});
    tick(); tick();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_alu_station.md
Name: rs_alu_station

Overview:
ALU reservation station for the out-of-order core, connected through the CDB_IF slave and RS2REG_STATUS_IF views.
- Accepts one renamed instruction per cycle from rename/issue.
- Queries the register status table for operand readiness and marks the destination busy.
- Captures missing operands from the CDB.
- Dispatches ready entries to up to FU_NUM ALUs under a valid/ready handshake.

Parameters:
RS_ENTRIES_NUM, 8, number of station entries
FU_NUM, 2, number of ALUs; also number of CDB broadcast lanes
REG_VAL_WIDTH, 64, operand/immediate width
PHYS_REG_W, 5, physical register address width (tag = physical register number)
ALU_OP_W, 4, alu_op encoding width (opaque here)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
new_valid_inst  in  1  new instruction offered this cycle
ctrl_alu_op  in  ALU_OP_W  ALU operation, passed through
ctrl_use_imm  in  1  1: op2 = immediate, src2 ignored
ctrl_reg_wb  in  1  instruction writes dst
src_reg1_addr / src_reg2_addr  in  PHYS_REG_W each  source physical regs
src_reg1_val / src_reg2_val  in  REG_VAL_WIDTH each  register-file values read at issue
dst_reg_addr  in  PHYS_REG_W  destination physical reg
immediate  in  REG_VAL_WIDTH  immediate
rs_full  out  1  no free entry
stat_src1_addr / stat_src2_addr  out  PHYS_REG_W  status query, equal to src addr inputs
stat_src1_ready / stat_src2_ready  in  1  status reply (combinational, same cycle)
stat_set_busy  out  1  mark stat_dst_addr busy
stat_dst_addr  out  PHYS_REG_W  destination being allocated
cdb_valid  in  FU_NUM  per-lane broadcast valid
cdb_tag  in  FU_NUM*PHYS_REG_W  per-lane tag, lane i at bits [i*PHYS_REG_W +: PHYS_REG_W]
cdb_val  in  FU_NUM*REG_VAL_WIDTH  per-lane value
fu_ready  in  FU_NUM  ALU i can accept
fu_valid  out  FU_NUM  dispatch pulse to ALU i
fu_op1 / fu_op2  out  FU_NUM*REG_VAL_WIDTH  operands per ALU
fu_dst  out  FU_NUM*PHYS_REG_W  destination tag per ALU
fu_alu_op  out  FU_NUM*ALU_OP_W  operation per ALU
fu_reg_wb  out  FU_NUM  writeback flag per ALU

Behaviour:
- Reset (async, reset=0):
  - All entries become invalid.
  - fu_valid=0, fu_op*/fu_dst/fu_alu_op/fu_reg_wb=0.
  - rs_full=0, stat_set_busy=0.
  - Releasing reset mid-operation leaves the station empty; in-flight entries are lost.
- Entry fields: valid, op1/op2 values, op1_rdy/op2_rdy, tag1/tag2, dst, alu_op, reg_wb.
- Allocation:
  - Condition: on a clk edge with new_valid_inst=1 and not full.
  - Target: the lowest-index free entry.
  - Operand 1 ready/value:
    - ready if stat_src1_ready, or if any CDB lane this cycle has a matching tag;
    - value comes from the CDB on a tag match, else from src_reg1_val.
  - Operand 2: same rule as operand 1. When ctrl_use_imm=1, op2 = immediate and op2_rdy=1.
  - Physical reg 0 is always ready.
- Full:
  - rs_full is combinational: all entries valid.
  - new_valid_inst while full is dropped; upstream must stall.
  - An entry freed by dispatch this cycle does not clear rs_full until the next cycle.
- stat_set_busy is combinational: new_valid_inst & !rs_full & ctrl_reg_wb & (dst≠0). stat_dst_addr = dst_reg_addr.
- Wakeup:
  - Each cycle, every valid entry with a not-ready operand compares its tag against all cdb_valid lanes.
  - On a match it captures cdb_val and sets ready at the edge.
  - If several lanes match, the lowest lane wins.
- Dispatch:
  - An entry is eligible when valid & op1_rdy & op2_rdy, using registered state. An entry woken this cycle dispatches next cycle at earliest.
  - For each ALU i in ascending order with fu_ready[i]=1, pick the lowest-index eligible entry not already picked this cycle.
  - At the edge: load ALU i's payload registers, drive fu_valid[i]=1 for exactly one cycle, and free the entry.
  - fu_valid deasserts the next cycle unless a new dispatch occurs.
  - At most one dispatch per ALU per cycle; up to FU_NUM dispatches per cycle.
  - Payload outputs hold their value after fu_valid drops.
- Latency: allocation at edge N gives earliest fu_valid during cycle N+1.
- An entry may allocate and be freed in different cycles only; it never dispatches in its allocation cycle.

Test Plan:
- Independent op: src1=R2 (ready, val 15), src2=R1 (ready, val 9), dst R3, add -> stat_set_busy for R3 at issue; next cycle fu_valid[0]=1, fu_op1=15, fu_op2=9, fu_dst=3.
- Dependent op with immediate: src1=R3 not ready, imm 33, dst R4 -> no dispatch; CDB lane0 tag 3 value 24 -> next cycle a fu_valid pulse with op1=24, op2=33, dst=4.
- CDB broadcast of tag 3 in the same cycle as allocation of an op reading R3 -> value captured at allocation; dispatch the following cycle.
- Fill all 8 entries with ops waiting on R7 -> rs_full=1; a 9th new_valid_inst is dropped; broadcast tag 7 -> two dispatch per cycle (one per ALU) until empty.
- fu_ready[0]=0, fu_ready[1]=1, two ready entries -> only ALU1 receives one per cycle; fu_valid[0] stays 0.
- Assert reset low with 3 valid entries -> all outputs zero immediately; after release, no dispatch without a new issue.
